ft_uart_tx: RTL and testbench

- UART transmitter that drains a show-ahead byte FIFO (`d_out` valid while `empty`=0; pop with a one-cycle read strobe) and serialises each byte onto `tx`.
- Serial format: 8N1-style frames, with optional parity and a configurable number of stop bits.
- It is the read-side counterpart to the FIFO writer in the UART echo path: the RX path fills the FIFO, and this block empties it onto the line.

---
 rtl/ft_uart_tx.sv | 156 +++++++++++++++
 tb/tb_ft_uart_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_uart_tx.sv
// rtl/ft_uart_tx.sv - UART transmitter draining a show-ahead byte FIFO onto a serial line
module ft_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_W       = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] fifo_d,
  input  logic              fifo_empty,
  output logic              fifo_r_en,
  output logic              tx,
  output logic              busy
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(DATA_W + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [1:0]        STOP_LAST = 2'(STOP_BITS - 1);
  localparam logic              PAR_INV   = (PARITY == 2);
  localparam logic              HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  state_t              state, state_nxt;
  logic [BAUD_W-1:0]   baud_cnt, baud_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic [1:0]          stop_cnt, stop_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic                par_bit, par_nxt;
  logic                tx_nxt, busy_nxt, r_en_nxt;
  logic                baud_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      fifo_r_en <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_nxt;
      bit_cnt   <= bit_nxt;
      stop_cnt  <= stop_nxt;
      shreg     <= shreg_nxt;
      par_bit   <= par_nxt;
      tx        <= tx_nxt;
      busy      <= busy_nxt;
      fifo_r_en <= r_en_nxt;
    end
  end

  // Outputs are computed one cycle ahead so tx/busy/fifo_r_en leave straight from flops.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    stop_nxt  = stop_cnt;
    shreg_nxt = shreg;
    par_nxt   = par_bit;
    tx_nxt    = tx;
    busy_nxt  = busy;
    r_en_nxt  = 1'b0;
    baud_last = (baud_cnt == BAUD_LAST);

    case (state)
      IDLE: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
        if (!fifo_empty) begin
          shreg_nxt = fifo_d;
          par_nxt   = (^fifo_d) ^ PAR_INV;
          r_en_nxt  = 1'b1;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
          baud_nxt  = '0;
          state_nxt = START;
        end
      end

      START: begin
        baud_nxt = baud_last ? '0 : baud_cnt + 1'b1;
        if (baud_last) begin
          state_nxt = DATA;
          bit_nxt   = '0;
          tx_nxt    = shreg[0];
        end
      end

      DATA: begin
        baud_nxt = baud_last ? '0 : baud_cnt + 1'b1;
        if (baud_last) begin
          if (bit_cnt == BIT_LAST) begin
            bit_nxt = '0;
            if (HAS_PAR) begin
              state_nxt = PAR;
              tx_nxt    = par_bit;
            end else begin
              state_nxt = STOP;
              stop_nxt  = '0;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_nxt   = bit_cnt + 1'b1;
            shreg_nxt = shreg >> 1;
            tx_nxt    = shreg_nxt[0];
          end
        end
      end

      PAR: begin
        baud_nxt = baud_last ? '0 : baud_cnt + 1'b1;
        if (baud_last) begin
          state_nxt = STOP;
          stop_nxt  = '0;
          tx_nxt    = 1'b1;
        end
      end

      STOP: begin
        baud_nxt = baud_last ? '0 : baud_cnt + 1'b1;
        tx_nxt   = 1'b1;
        if (baud_last) begin
          if (stop_cnt == STOP_LAST) begin
            stop_nxt  = '0;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            stop_nxt = stop_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ft_uart_tx.sv
// tb/tb_ft_uart_tx.sv - self-checking bench for ft_uart_tx
`timescale 1ns/1ps
module tb_ft_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // u0: no parity, one stop bit, fed by a queue-backed show-ahead FIFO model
  logic       e0, r0, tx0, b0;
  logic [7:0] d0;
  logic       m_empty = 1'b1;
  logic [7:0] m_d = 8'h00;
  logic       noise_mode = 1'b0;
  logic       nz_e = 1'b1;
  logic [7:0] nz_d = 8'h00;
  logic [7:0] fq0[$];
  logic [7:0] exp_q[$];
  int         r0_count = 0;

  assign e0 = noise_mode ? nz_e : m_empty;
  assign d0 = noise_mode ? nz_d : m_d;

  // u1: even parity, two stop bits; u2: odd parity, one stop bit
  logic       e1 = 1'b1, e2 = 1'b1;
  logic [7:0] d1 = 8'h00, d2 = 8'h00;
  logic       r1, tx1, b1, r2, tx2, b2;

  ft_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .fifo_d(d0), .fifo_empty(e0),
    .fifo_r_en(r0), .tx(tx0), .busy(b0));

  ft_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .fifo_d(d1), .fifo_empty(e1),
    .fifo_r_en(r1), .tx(tx1), .busy(b1));

  ft_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .fifo_d(d2), .fifo_empty(e2),
    .fifo_r_en(r2), .tx(tx2), .busy(b2));

  always @(posedge clk) begin
    if (r0 === 1'b1) begin
      r0_count <= r0_count + 1;
      if (!noise_mode && fq0.size() > 0) void'(fq0.pop_front());
    end
  end

  // Empty/head refresh away from the sampling edge, so the flag trails the pop.
  always @(negedge clk) begin
    m_empty <= (fq0.size() == 0);
    m_d     <= (fq0.size() != 0) ? fq0[0] : 8'h00;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_r0(output int lat, output bit seen);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (r0 === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
  endtask

  // Line decoder for u0: samples mid-bit, abandons frames cut by reset.
  logic [7:0] mon_rx;
  logic       mon_ok, mon_start, mon_stop;
  logic [7:0] mon_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx0 === 1'b0) begin
        mon_ok = 1'b1;
        repeat (2) @(negedge clk);
        if (rst_n !== 1'b1) mon_ok = 1'b0;
        mon_start = tx0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          if (rst_n !== 1'b1) mon_ok = 1'b0;
          mon_rx[i] = tx0;
        end
        repeat (CPB) @(negedge clk);
        if (rst_n !== 1'b1) mon_ok = 1'b0;
        mon_stop = tx0;
        if (mon_ok) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_frame", int'(mon_rx), -1);
          end else begin
            mon_exp = exp_q.pop_front();
            check("sb_byte", int'(mon_rx), int'(mon_exp));
            check("sb_framing", int'({mon_start, mon_stop}), 1);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  vec_t       vecs[3];
  int         lat, tx_bad, busy_n, pulse_n, base, ngaps, run, gap_bad, idle_bad;
  int         b1n, b2n, stop1, p1n, p2n;
  bit         seen;
  logic       seen_busy, par1, par2;
  logic [9:0] fr;

  initial begin
    // frame bit i is the i-th bit on the line: start, D0..D7, stop
    vecs[0].data = 8'hA5; vecs[0].frame = 10'b1101001010;
    vecs[1].data = 8'h3C; vecs[1].frame = 10'b1001111000;
    vecs[2].data = 8'h81; vecs[2].frame = 10'b1100000010;

    // reset and long idle with an empty FIFO
    base = r0_count;
    repeat (3) @(negedge clk);
    check("reset_tx", int'(tx0), 1);
    check("reset_busy", int'(b0), 0);
    check("reset_r_en", int'(r0), 0);
    idle_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 10) rst_n = 1'b1;
      if (tx0 !== 1'b1 || b0 !== 1'b0 || r0 !== 1'b0) idle_bad++;
      if (tx1 !== 1'b1 || b1 !== 1'b0 || r1 !== 1'b0) idle_bad++;
    end
    check("idle_violations", idle_bad, 0);
    check("idle_pops", r0_count - base, 0);

    // single-byte frames, cycle-exact waveform
    for (int v = 0; v < 3; v++) begin
      fr = vecs[v].frame;
      tx_bad = 0; busy_n = 0; pulse_n = 0;
      @(posedge clk); #1;
      fq0.push_back(vecs[v].data);
      exp_q.push_back(vecs[v].data);
      wait_r0(lat, seen);
      check("start_latency", lat, 2);
      if (seen) begin
        for (int k = 0; k < 40; k++) begin
          if (k > 0) @(negedge clk);
          if (tx0 !== fr[k/4]) tx_bad++;
          if (b0 === 1'b1) busy_n++;
          if (r0 === 1'b1) pulse_n++;
        end
        @(negedge clk);
        check("frame_tx_bits", tx_bad, 0);
        check("frame_busy_cycles", busy_n, 40);
        check("frame_r_en_pulses", pulse_n, 1);
        check("post_frame_idle", int'({tx0, b0}), 2);
      end
      repeat (5) @(negedge clk);
    end

    // three bytes preloaded: back-to-back frames
    base = r0_count;
    @(posedge clk); #1;
    fq0.push_back(8'h00); fq0.push_back(8'hFF); fq0.push_back(8'h55);
    exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h55);
    ngaps = 0; run = 0; gap_bad = 0; busy_n = 0; seen_busy = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (b0 === 1'b1) begin
        busy_n++;
        if (seen_busy && run > 0) begin
          ngaps++;
          if (run != 1) gap_bad++;
        end
        run = 0;
        seen_busy = 1'b1;
      end else if (seen_busy) begin
        run++;
      end
    end
    check("burst_gap_count", ngaps, 2);
    check("burst_gap_len_bad", gap_bad, 0);
    check("burst_pops", r0_count - base, 3);
    check("burst_busy_cycles", busy_n, 120);
    check("burst_fifo_drained", fq0.size(), 0);
    check("burst_empty_flag", int'(e0), 1);

    // parity and two stop bits on byte 0x07
    @(posedge clk); #1;
    d1 = 8'h07; e1 = 1'b0; d2 = 8'h07; e2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (r1 === 1'b1) seen = 1'b1;
    end
    e1 = 1'b1; e2 = 1'b1;
    check("parity_start_seen", int'(seen), 1);
    b1n = 0; b2n = 0; stop1 = 0; p1n = 0; p2n = 0; par1 = 1'bx; par2 = 1'bx;
    for (int k = 0; k < 60; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 37) begin par1 = tx1; par2 = tx2; end
      if (b1 === 1'b1) b1n++;
      if (b2 === 1'b1) b2n++;
      if (k >= 40 && b1 === 1'b1 && tx1 === 1'b1) stop1++;
      if (r1 === 1'b1) p1n++;
      if (r2 === 1'b1) p2n++;
    end
    check("even_parity_bit", int'(par1), 1);
    check("odd_parity_bit", int'(par2), 0);
    check("two_stop_high_cycles", stop1, 8);
    check("even_2stop_busy_cycles", b1n, 48);
    check("odd_1stop_busy_cycles", b2n, 44);
    check("parity_r_en_pulses", p1n + p2n, 2);

    // reset during data bit 3
    base = r0_count;
    @(posedge clk); #1;
    fq0.push_back(8'h96);
    wait_r0(lat, seen);
    check("midreset_start_seen", int'(seen), 1);
    repeat (17) @(negedge clk);
    check("midreset_busy_before", int'(b0), 1);
    rst_n = 1'b0;
    #1;
    check("midreset_tx", int'(tx0), 1);
    check("midreset_busy", int'(b0), 0);
    check("midreset_r_en", int'(r0), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("midreset_no_reread", r0_count - base, 1);
    base = r0_count;
    @(posedge clk); #1;
    fq0.push_back(8'h3C);
    exp_q.push_back(8'h3C);
    wait_r0(lat, seen);
    check("postreset_start_latency", lat, 2);
    repeat (45) @(negedge clk);
    check("postreset_pops", r0_count - base, 1);

    // toggling FIFO inputs throughout a frame
    base = r0_count;
    @(negedge clk);
    nz_d = 8'hC3; nz_e = 1'b0; noise_mode = 1'b1;
    exp_q.push_back(8'hC3);
    wait_r0(lat, seen);
    check("noise_start_seen", int'(seen), 1);
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      if (k == 38) begin
        nz_e = 1'b1;
      end else begin
        nz_d = 8'($urandom);
        nz_e = 1'($urandom);
      end
    end
    repeat (10) @(negedge clk);
    noise_mode = 1'b0;
    check("noise_pops", r0_count - base, 1);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
